mask_share_gen: RTL

Upstream feeder for the registered masked XOR gadget stage: accepts unmasked operand bits `a`, `b` over a valid/ready handshake, splits each into two Boolean shares using fresh mask bits from an internal 16-bit LFSR, and supplies the three refresh bits `r0..r2` from the same LFSR. One registered output slot holds a complete share set (`a0,a1,b0,b1,r0,r1,r2`) stable until the downstream stage consumes it. The block also provides runtime reseeding, a transfer counter, and a reseed-request flag.

---
 rtl/mask_share_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/mask_share_gen.sv
// Share generator feeding the masked XOR gadget: splits a/b into Boolean shares
// with fresh LFSR masks and supplies refresh bits through a one-entry output slot.
module mask_share_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        a,
  input  logic        b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        a0,
  output logic        a1,
  output logic        b0,
  output logic        b1,
  output logic        r0,
  output logic        r1,
  output logic        r2,
  output logic [7:0]  share_cnt,
  output logic        reseed_req
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e       state;
  slot_e       state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_adv;
  logic [15:0] seed_eff;
  logic        accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Five steps per transfer so every mask/refresh bit of a set is fresh.
  always_comb begin
    lfsr_adv = lfsr;
    for (int unsigned i = 0; i < 5; i++) begin
      lfsr_adv = lfsr_step(lfsr_adv);
    end
  end

  // A zero seed would lock the LFSR up, so it is replaced by the reset seed.
  assign seed_eff  = (seed_in == '0) ? SEED : seed_in;

  assign out_valid = (state == FULL);
  assign in_ready  = !seed_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)         state_nxt = FULL;
        else if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr <= SEED;
    else if (seed_load) lfsr <= seed_eff;
    else if (accept)    lfsr <= lfsr_adv;
  end

  // Mask bits are taken from the state before it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= 1'b0;
      a1 <= 1'b0;
      b0 <= 1'b0;
      b1 <= 1'b0;
      r0 <= 1'b0;
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else if (accept) begin
      a0 <= a ^ lfsr[15];
      a1 <= lfsr[15];
      b0 <= b ^ lfsr[14];
      b1 <= lfsr[14];
      r0 <= lfsr[13];
      r1 <= lfsr[12];
      r2 <= lfsr[11];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share_cnt  <= '0;
      reseed_req <= 1'b0;
    end else if (seed_load) begin
      reseed_req <= 1'b0;
    end else if (accept) begin
      share_cnt <= share_cnt + 8'd1;
      if (share_cnt == '1) reseed_req <= 1'b1;
    end
  end

endmodule
